// File: rtl/regfile_wport_arb.sv
// Single integer register-file write port shared by WB, buffered long-latency results and debug.
// Also tracks outstanding long-latency destinations and flags a WB bubble when buffered results starve.
module regfile_wport_arb #(
  parameter  int unsigned LLU_DEPTH  = 4,
  parameter  int unsigned STARVE_MAX = 8,
  localparam int unsigned REG_W      = 5,
  localparam int unsigned DATA_W     = 32,
  localparam int unsigned NREG       = 2 ** REG_W,
  localparam int unsigned CNT_W      = $clog2(LLU_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              llu_issue,
  input  logic [REG_W-1:0]  llu_issue_rd,
  input  logic              llu_valid,
  input  logic [REG_W-1:0]  llu_rd,
  input  logic [DATA_W-1:0] llu_data,
  output logic              llu_ready,
  input  logic              dbg_valid,
  input  logic [REG_W-1:0]  dbg_rd,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              dbg_ready,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [NREG-1:0]   rd_busy,
  output logic              wb_hold,
  output logic [CNT_W-1:0]  fifo_count
);

  localparam int unsigned PTR_W = $clog2(LLU_DEPTH);
  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  wr_req_t           fifo_mem [LLU_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_nxt;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  wr_req_t           head;
  wr_req_t           llu_req;

  logic              grant;
  wr_req_t           grant_req;

  logic              retire_valid;
  logic [REG_W-1:0]  retire_rd;
  logic [NREG-1:0]   busy_set;
  logic [NREG-1:0]   busy_clr;

  logic [STV_W-1:0]  starve_cnt;
  logic [STV_W-1:0]  starve_nxt;
  logic              hold_nxt;

  // Readiness is derived from the registered count only, so a full FIFO refuses even while popping.
  assign fifo_empty = (fifo_count == '0);
  assign llu_ready  = (fifo_count < CNT_W'(LLU_DEPTH));
  assign push       = llu_valid && llu_ready;
  assign pop        = !wb_valid && !fifo_empty;
  assign dbg_ready  = dbg_valid && !wb_valid && fifo_empty;
  assign head       = fifo_mem[rd_ptr];
  assign llu_req    = '{rd: llu_rd, data: llu_data};

  // Fixed-priority grant: WB, then buffered LLU head, then debug.
  always_comb begin
    grant     = 1'b0;
    grant_req = '0;
    if (wb_valid) begin
      grant          = 1'b1;
      grant_req.rd   = wb_rd;
      grant_req.data = wb_data;
    end else if (!fifo_empty) begin
      grant     = 1'b1;
      grant_req = head;
    end else if (dbg_valid) begin
      grant          = 1'b1;
      grant_req.rd   = dbg_rd;
      grant_req.data = dbg_data;
    end
  end

  always_comb begin
    count_nxt = fifo_count;
    unique case ({push, pop})
      2'b10:   count_nxt = fifo_count + CNT_W'(1);
      2'b01:   count_nxt = fifo_count - CNT_W'(1);
      default: count_nxt = fifo_count;
    endcase
  end

  // Result storage needs no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= llu_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= count_nxt;
    end
  end

  // Write port register; r0 requests are consumed but never enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= grant && (grant_req.rd != '0);
      if (grant) begin
        rf_waddr <= grant_req.rd;
        rf_wdata <= grant_req.data;
      end
    end
  end

  // A popped result retires one cycle later, on the same edge the regfile samples it.
  always_comb begin
    busy_clr = '0;
    busy_set = '0;
    if (retire_valid) busy_clr[retire_rd] = 1'b1;
    if (llu_issue && (llu_issue_rd != '0)) busy_set[llu_issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_valid <= 1'b0;
      retire_rd    <= '0;
      rd_busy      <= '0;
    end else begin
      retire_valid <= pop;
      retire_rd    <= head.rd;
      rd_busy      <= (rd_busy & ~busy_clr) | busy_set;
    end
  end

  // Starvation counter saturates at STARVE_MAX; the hold drops on the edge ending the pop.
  always_comb begin
    starve_nxt = starve_cnt;
    if (fifo_empty || pop) begin
      starve_nxt = '0;
    end else if (starve_cnt < STV_W'(STARVE_MAX)) begin
      starve_nxt = starve_cnt + STV_W'(1);
    end
    hold_nxt = !pop && (starve_cnt == STV_W'(STARVE_MAX));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      wb_hold    <= 1'b0;
    end else begin
      starve_cnt <= starve_nxt;
      wb_hold    <= hold_nxt;
    end
  end

endmodule

// File: tb/tb_regfile_wport_arb.sv
// Randomized and directed bench for regfile_wport_arb against a queue-based cycle model.
module tb_regfile_wport_arb;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned SMAX  = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        llu_issue;
  logic [4:0]  llu_issue_rd;
  logic        llu_valid;
  logic [4:0]  llu_rd;
  logic [31:0] llu_data;
  logic        llu_ready;
  logic        dbg_valid;
  logic [4:0]  dbg_rd;
  logic [31:0] dbg_data;
  logic        dbg_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] rd_busy;
  logic        wb_hold;
  logic [2:0]  fifo_count;

  regfile_wport_arb #(.LLU_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .llu_issue(llu_issue), .llu_issue_rd(llu_issue_rd),
    .llu_valid(llu_valid), .llu_rd(llu_rd), .llu_data(llu_data), .llu_ready(llu_ready),
    .dbg_valid(dbg_valid), .dbg_rd(dbg_rd), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rd_busy(rd_busy), .wb_hold(wb_hold), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: queue of buffered results plus the expected write of the current cycle.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        q[$];
  bit          e_we;
  logic [4:0]  e_addr;
  logic [31:0] e_data;
  bit          e_llu;
  logic [4:0]  e_llu_rd;
  logic [31:0] e_busy;
  bit          e_hold;
  int          run;

  task automatic model_reset();
    q.delete();
    e_we = 0; e_addr = '0; e_data = '0;
    e_llu = 0; e_llu_rd = '0;
    e_busy = '0; e_hold = 0; run = 0;
  endtask

  task automatic drive_idle();
    wb_valid = 0; wb_rd = '0; wb_data = '0;
    llu_issue = 0; llu_issue_rd = '0;
    llu_valid = 0; llu_rd = '0; llu_data = '0;
    dbg_valid = 0; dbg_rd = '0; dbg_data = '0;
  endtask

  // Called just after a rising edge with inputs already driven; checks, advances model, waits one cycle.
  task automatic tick();
    bit          empty, rdy, pop, dbg_g, g;
    logic [4:0]  grd;
    logic [31:0] gdat;
    logic [31:0] nbusy;
    ent_t        h;
    #1;
    empty = (q.size() == 0);
    rdy   = (q.size() < DEPTH);
    pop   = !wb_valid && !empty;
    dbg_g = dbg_valid && !wb_valid && empty;

    check("llu_ready", 32'(llu_ready), 32'(rdy));
    check("dbg_ready", 32'(dbg_ready), 32'(dbg_g));
    check("fifo_count", 32'(fifo_count), 32'(q.size()));
    check("rf_we", 32'(rf_we), 32'(e_we));
    if (e_we) begin
      check("rf_waddr", 32'(rf_waddr), 32'(e_addr));
      check("rf_wdata", rf_wdata, e_data);
    end
    check("rd_busy", rd_busy, e_busy);
    check("wb_hold", 32'(wb_hold), 32'(e_hold));

    nbusy = e_busy;
    if (e_llu) nbusy[e_llu_rd] = 1'b0;
    if (llu_issue && llu_issue_rd != 5'd0) nbusy[llu_issue_rd] = 1'b1;

    e_hold = !empty && !pop && (run >= SMAX);
    run    = (empty || pop) ? 0 : run + 1;

    g = 1; e_llu = 0; grd = '0; gdat = '0;
    if (wb_valid) begin
      grd = wb_rd; gdat = wb_data;
    end else if (pop) begin
      h = q.pop_front();
      grd = h.rd; gdat = h.data; e_llu = 1; e_llu_rd = h.rd;
    end else if (dbg_g) begin
      grd = dbg_rd; gdat = dbg_data;
    end else begin
      g = 0;
    end
    if (llu_valid && rdy) q.push_back('{rd: llu_rd, data: llu_data});
    e_we = g && (grd != 5'd0);
    if (g) begin
      e_addr = grd; e_data = gdat;
    end
    e_busy = nbusy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    #2;
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_rf_waddr", 32'(rf_waddr), 32'd0);
    check("rst_rf_wdata", rf_wdata, 32'd0);
    check("rst_rd_busy", rd_busy, 32'd0);
    check("rst_wb_hold", 32'(wb_hold), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_llu_ready", 32'(llu_ready), 32'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ticks(input int n);
    drive_idle();
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rand_phase(input int cycles, input int wb_pct);
    for (int i = 0; i < cycles; i++) begin
      wb_valid     = ($urandom_range(99) < 32'(wb_pct));
      wb_rd        = 5'($urandom_range(31));
      wb_data      = $urandom;
      llu_issue    = ($urandom_range(99) < 30);
      llu_issue_rd = 5'($urandom_range(31));
      llu_valid    = ($urandom_range(99) < 45);
      llu_rd       = 5'($urandom_range(31));
      llu_data     = $urandom;
      dbg_valid    = ($urandom_range(99) < 30);
      dbg_rd       = 5'($urandom_range(31));
      dbg_data     = $urandom;
      tick();
    end
  endtask

  initial begin
    drive_idle();
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Reset with three buffered results and r1/r2 outstanding.
    llu_issue = 1; llu_issue_rd = 5'd1; tick();
    llu_issue_rd = 5'd2; tick();
    llu_issue = 0;
    wb_valid = 1; wb_rd = 5'd4; wb_data = 32'h1111;
    llu_valid = 1;
    for (int i = 0; i < 3; i++) begin
      llu_rd = 5'(10 + i); llu_data = 32'(32'hA0 + i); tick();
    end
    llu_valid = 0; tick();
    do_reset();

    // WB and LLU offered together; WB writes first, LLU result follows.
    llu_issue = 1; llu_issue_rd = 5'd7; tick();
    drive_idle();
    wb_valid = 1; wb_rd = 5'd5; wb_data = 32'hDEAD;
    llu_valid = 1; llu_rd = 5'd7; llu_data = 32'hBEEF;
    tick();
    idle_ticks(4);

    // Fill the FIFO behind continuous WB traffic, offer a fifth, then drain.
    wb_valid = 1; wb_rd = 5'd6; wb_data = 32'h600D;
    llu_valid = 1;
    for (int i = 0; i < 5; i++) begin
      llu_rd = 5'(20 + i); llu_data = 32'(32'hC0 + i); tick();
    end
    llu_valid = 0;
    for (int i = 0; i < 3; i++) tick();
    idle_ticks(6);

    // Starvation: one buffered result blocked by WB long enough to raise the hold.
    llu_valid = 1; llu_rd = 5'd12; llu_data = 32'h5A5A; tick();
    llu_valid = 0;
    wb_valid = 1; wb_rd = 5'd13; wb_data = 32'h77;
    for (int i = 0; i < 12; i++) tick();
    idle_ticks(4);

    // Debug to r0 is granted but writes nothing; debug then waits behind WB.
    dbg_valid = 1; dbg_rd = 5'd0; dbg_data = 32'h1234; tick();
    dbg_rd = 5'd3; dbg_data = 32'h3333;
    wb_valid = 1; wb_rd = 5'd8; wb_data = 32'h88;
    tick(); tick();
    wb_valid = 0; tick();
    idle_ticks(2);

    // Reissue to r9 on the edge its previous result retires: the bit stays set.
    llu_issue = 1; llu_issue_rd = 5'd9; tick();
    drive_idle();
    llu_valid = 1; llu_rd = 5'd9; llu_data = 32'h9999; tick();
    drive_idle(); tick();
    llu_issue = 1; llu_issue_rd = 5'd9; tick();
    drive_idle(); tick(); tick();
    llu_valid = 1; llu_rd = 5'd9; llu_data = 32'h9A9A; tick();
    idle_ticks(4);

    rand_phase(1500, 50);
    rand_phase(1500, 90);
    do_reset();
    rand_phase(1500, 20);
    rand_phase(1000, 70);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
